// File: rtl/jk_pkg.sv
// Shared definitions for jk_counter_bank: mode encodings and the per-bit J/K drive function.
package jk_pkg;

  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_UP = 2'b01;
  localparam logic [1:0] MODE_DN = 2'b10;
  localparam logic [1:0] MODE_LD = 2'b11;

  typedef struct packed {
    logic j;
    logic k;
  } jk_drive_t;

  // Map a mode and the bit's next target onto JK inputs so every mode keeps JK semantics.
  function automatic jk_drive_t jk_bit_drive(input logic [1:0] mode, input logic q,
                                             input logic target, input logic j,
                                             input logic k);
    jk_drive_t r;
    r = '0;
    case (mode)
      MODE_JK: begin
        r.j = j;
        r.k = k;
      end
      MODE_UP, MODE_DN: begin
        r.j = q ^ target;
        r.k = q ^ target;
      end
      default: begin
        r.j = target;
        r.k = ~target;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single edge-triggered JK flip-flop with synchronous active-high reset and enable.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_counter_bank.sv
// Bank of JK flip-flops usable as raw JK storage, modulo-MOD up/down counter or clamped load register.
// Define JK_CNT_SATURATE_EN to make UP/DOWN saturate at their limits instead of wrapping.
module jk_counter_bank
  import jk_pkg::*;
#(
  parameter int unsigned     WIDTH = 4,
  parameter longint unsigned MOD   = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 64'd1);

  logic             up_lim;
  logic             dn_lim;
  logic             limit;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] dn_val;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] target;

  // Next value per mode; out-of-range states count as limit hits.
  always_comb begin
    up_lim = (q >= MAX);
    dn_lim = (q == '0) || (q > MAX);
`ifdef JK_CNT_SATURATE_EN
    up_val = up_lim ? MAX : q + 1'b1;
    dn_val = (q == '0) ? '0 : ((q > MAX) ? MAX : q - 1'b1);
`else
    up_val = up_lim ? '0 : q + 1'b1;
    dn_val = dn_lim ? MAX : q - 1'b1;
`endif
    ld_val = (d > MAX) ? MAX : d;
    target = q;
    limit  = 1'b0;
    case (mode)
      MODE_UP: begin
        target = up_val;
        limit  = up_lim;
      end
      MODE_DN: begin
        target = dn_val;
        limit  = dn_lim;
      end
      MODE_LD: target = ld_val;
      default: ;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_drive_t drv;
    assign drv = jk_bit_drive(mode, q[i], target[i], j[i], k[i]);
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .j   (drv.j),
      .k   (drv.k),
      .q   (q[i]),
      .qbar(qbar[i])
    );
  end

  // tc pulses on each limit edge; ovf is sticky until LOAD or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (!en) begin
      tc <= 1'b0;
    end else begin
      tc <= limit;
      if (mode == MODE_LD) begin
        ovf <= 1'b0;
      end else if (limit) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jk_counter_bank.sv
// Table-driven scoreboard bench for jk_counter_bank (WIDTH=4/MOD=10 and WIDTH=1/MOD=2 instances).
// Expectations follow JK_CNT_SATURATE_EN when the bench is built with it defined.
module tb_jk_counter_bank;
  import jk_pkg::*;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc;
    logic       ovf;
  } vec_t;

  typedef struct packed {
    logic [3:0] q;
    logic       tc;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, en_a = 1'b0;
  logic [1:0] mode_a = MODE_JK;
  logic [3:0] j_a = '0, k_a = '0, d_a = '0;
  logic [3:0] q_a, qbar_a;
  logic       tc_a, ovf_a;

  logic       rst_b = 1'b1, en_b = 1'b0;
  logic [1:0] mode_b = MODE_JK;
  logic [0:0] j_b = '0, k_b = '0, d_b = '0;
  logic [0:0] q_b, qbar_b;
  logic       tc_b, ovf_b;

  jk_counter_bank #(.WIDTH(4), .MOD(10)) u_dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .j(j_a), .k(k_a), .d(d_a),
    .q(q_a), .qbar(qbar_a), .tc(tc_a), .ovf(ovf_a)
  );

  jk_counter_bank #(.WIDTH(1), .MOD(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .j(j_b), .k(k_b), .d(d_b),
    .q(q_b), .qbar(qbar_b), .tc(tc_b), .ovf(ovf_b)
  );

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic va(input logic r, input logic e, input logic [1:0] m, input logic [3:0] jj,
                    input logic [3:0] kk, input logic [3:0] dd, input logic [3:0] eq,
                    input logic et, input logic eo);
    tbl_a.push_back('{r, e, m, jj, kk, dd, eq, et, eo});
  endtask

  task automatic vb(input logic r, input logic e, input logic [1:0] m, input logic dd,
                    input logic eq, input logic et, input logic eo);
    tbl_b.push_back('{r, e, m, 4'h0, 4'h0, {3'b0, dd}, {3'b0, eq}, et, eo});
  endtask

  task automatic run_a(input vec_t t, input int step);
    exp_t e;
    @(negedge clk);
    rst_a = t.rst; en_a = t.en; mode_a = t.mode; j_a = t.j; k_a = t.k; d_a = t.d;
    sb.push_back('{t.q, t.tc, t.ovf});
    @(posedge clk);
    #1;
    n_chk++;
    if (sb.size() == 0) begin
      $display("FAIL bank4 step %0d: scoreboard empty", step);
    end else begin
      e = sb.pop_front();
      if ({q_a, qbar_a, tc_a, ovf_a} === {e.q, ~e.q, e.tc, e.ovf}) n_pass++;
      else $display("FAIL bank4 step %0d: got q=%h qbar=%h tc=%b ovf=%b, want q=%h qbar=%h tc=%b ovf=%b",
                    step, q_a, qbar_a, tc_a, ovf_a, e.q, ~e.q, e.tc, e.ovf);
    end
  endtask

  task automatic run_b(input vec_t t, input int step);
    exp_t e;
    @(negedge clk);
    rst_b = t.rst; en_b = t.en; mode_b = t.mode; d_b = t.d[0:0];
    sb.push_back('{t.q, t.tc, t.ovf});
    @(posedge clk);
    #1;
    n_chk++;
    if (sb.size() == 0) begin
      $display("FAIL bank1 step %0d: scoreboard empty", step);
    end else begin
      e = sb.pop_front();
      if ({q_b, qbar_b, tc_b, ovf_b} === {e.q[0], ~e.q[0], e.tc, e.ovf}) n_pass++;
      else $display("FAIL bank1 step %0d: got q=%b qbar=%b tc=%b ovf=%b, want q=%b qbar=%b tc=%b ovf=%b",
                    step, q_b, qbar_b, tc_b, ovf_b, e.q[0], ~e.q[0], e.tc, e.ovf);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset (mode/en ignored), then raw JK behaviour.
    va(1, 1, MODE_UP, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
    va(1, 0, MODE_JK, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
    va(0, 1, MODE_JK, 4'hA, 4'h6, 4'h0, 4'hA, 0, 0);
    va(0, 1, MODE_JK, 4'hF, 4'hF, 4'h0, 4'h5, 0, 0);
    va(0, 1, MODE_LD, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
    // UP through MOD-1 and past the limit.
    for (int i = 1; i <= 9; i++) va(0, 1, MODE_UP, 4'h0, 4'h0, 4'h0, 4'(i), 0, 0);
`ifdef JK_CNT_SATURATE_EN
    for (int i = 0; i < 3; i++) va(0, 1, MODE_UP, 4'h0, 4'h0, 4'h0, 4'h9, 1, 1);
`else
    va(0, 1, MODE_UP, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1);
    va(0, 1, MODE_UP, 4'h0, 4'h0, 4'h0, 4'h1, 0, 1);
    va(0, 1, MODE_UP, 4'h0, 4'h0, 4'h0, 4'h2, 0, 1);
`endif
    // JK leaves ovf alone; DOWN from an out-of-range state lands on MOD-1.
    va(0, 1, MODE_JK, 4'hF, 4'h0, 4'h0, 4'hF, 0, 1);
    va(0, 1, MODE_DN, 4'h0, 4'h0, 4'h0, 4'h9, 1, 1);
    va(0, 0, MODE_DN, 4'h0, 4'h0, 4'h0, 4'h9, 0, 1);
    for (int i = 8; i >= 0; i--) va(0, 1, MODE_DN, 4'h0, 4'h0, 4'h0, 4'(i), 0, 1);
`ifdef JK_CNT_SATURATE_EN
    va(0, 1, MODE_DN, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1);
    va(0, 1, MODE_DN, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1);
`else
    va(0, 1, MODE_DN, 4'h0, 4'h0, 4'h0, 4'h9, 1, 1);
    va(0, 1, MODE_DN, 4'h0, 4'h0, 4'h0, 4'h8, 0, 1);
`endif
    // LOAD clamps and clears ovf; en=0 holds even at the count limit.
    va(0, 1, MODE_LD, 4'h0, 4'h0, 4'hC, 4'h9, 0, 0);
    for (int i = 0; i < 3; i++) va(0, 0, MODE_UP, 4'h0, 4'h0, 4'h0, 4'h9, 0, 0);
    va(0, 1, MODE_LD, 4'h0, 4'h0, 4'h9, 4'h9, 0, 0);
    va(0, 1, MODE_LD, 4'h0, 4'h0, 4'hA, 4'h9, 0, 0);
    va(0, 1, MODE_LD, 4'h0, 4'h0, 4'h3, 4'h3, 0, 0);
    va(0, 1, MODE_UP, 4'h0, 4'h0, 4'h0, 4'h4, 0, 0);
    va(0, 1, MODE_UP, 4'h0, 4'h0, 4'h0, 4'h5, 0, 0);
    va(1, 1, MODE_UP, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
    va(0, 1, MODE_UP, 4'h0, 4'h0, 4'h0, 4'h1, 0, 0);

    // Single-bit bank, modulus 2: back-to-back limit edges.
    vb(1, 1, MODE_UP, 1'b0, 1'b0, 0, 0);
`ifdef JK_CNT_SATURATE_EN
    vb(0, 1, MODE_UP, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 5; i++) vb(0, 1, MODE_UP, 1'b0, 1'b1, 1, 1);
`else
    for (int i = 0; i < 3; i++) begin
      vb(0, 1, MODE_UP, 1'b0, 1'b1, 0, (i != 0));
      vb(0, 1, MODE_UP, 1'b0, 1'b0, 1, 1);
    end
`endif
    vb(0, 1, MODE_LD, 1'b1, 1'b1, 0, 0);
    vb(0, 1, MODE_DN, 1'b0, 1'b0, 0, 0);
`ifdef JK_CNT_SATURATE_EN
    vb(0, 1, MODE_DN, 1'b0, 1'b0, 1, 1);
`else
    vb(0, 1, MODE_DN, 1'b0, 1'b1, 1, 1);
`endif
    vb(0, 0, MODE_DN, 1'b0, q_exp_last(), 0, 1);

    repeat (2) @(posedge clk);
    foreach (tbl_a[i]) run_a(tbl_a[i], i);
    foreach (tbl_b[i]) run_b(tbl_b[i], i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  function automatic logic q_exp_last();
`ifdef JK_CNT_SATURATE_EN
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

endmodule
